// File: rtl/diffio_checker_prbs_engine.sv
// PRBS7 (x^7+x^6+1) bit-level generator and self-synchronising checker for the
// differential IO loopback test, advanced by the CLK_EN bit strobe.
module diffio_checker_prbs_engine #(
  parameter int unsigned SYNC_BITS    = 16,
  parameter int unsigned SYNC_TIMEOUT = 1024,
  parameter int unsigned BIT_CNT_W    = 32,
  parameter int unsigned ERR_CNT_W    = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CLK_EN,
  input  logic                 START,
  input  logic                 STOP,
  input  logic [BIT_CNT_W-1:0] TEST_LENGTH,
  input  logic                 RX_DATA,
  output logic                 TX_DATA,
  output logic                 BUSY,
  output logic                 LOCKED,
  output logic                 DONE,
  output logic                 SYNC_FAIL,
  output logic [BIT_CNT_W-1:0] BIT_CNT,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam int unsigned GOOD_W = $clog2(SYNC_BITS + 1);
  localparam int unsigned TO_W   = $clog2(SYNC_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_CHECK, S_DONE} state_t;

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic [6:0]           lfsr;
  logic [6:0]           rx_sr;
  logic [GOOD_W-1:0]    good_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic [BIT_CNT_W-1:0] len_q;

  logic [6:0]           rx_sr_nxt_c;
  logic                 err_c;
  logic                 active_c;
  logic [GOOD_W-1:0]    good_inc_c;
  logic [TO_W-1:0]      to_inc_c;
  logic [BIT_CNT_W:0]   bit_inc_c;

  // RX_DATA is asynchronous to CLK
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_m <= 1'b0;
      rx_s <= 1'b0;
    end else begin
      rx_m <= RX_DATA;
      rx_s <= rx_m;
    end
  end

  // Prediction from the last 7 received bits; an all-zero window counts as an error
  always_comb begin
    rx_sr_nxt_c = {rx_sr[5:0], rx_s};
    err_c       = (rx_s != (rx_sr[6] ^ rx_sr[5])) || (rx_sr_nxt_c == 7'h00);
    active_c    = (state == S_SYNC) || (state == S_CHECK);
    good_inc_c  = good_cnt + GOOD_W'(1);
    to_inc_c    = to_cnt + TO_W'(1);
    bit_inc_c   = {1'b0, BIT_CNT} + (BIT_CNT_W + 1)'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      lfsr      <= 7'h7F;
      rx_sr     <= 7'h00;
      good_cnt  <= '0;
      to_cnt    <= '0;
      len_q     <= '0;
      TX_DATA   <= 1'b0;
      BUSY      <= 1'b0;
      LOCKED    <= 1'b0;
      DONE      <= 1'b0;
      SYNC_FAIL <= 1'b0;
      BIT_CNT   <= '0;
      ERR_CNT   <= '0;
    end else begin
      // TX keeps toggling in DONE so the link stays active
      if (CLK_EN && (state != S_IDLE)) begin
        lfsr    <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        TX_DATA <= lfsr[6];
      end
      if (CLK_EN && active_c) begin
        rx_sr <= rx_sr_nxt_c;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (START && !STOP) begin
            state     <= S_SYNC;
            BUSY      <= 1'b1;
            LOCKED    <= 1'b0;
            DONE      <= 1'b0;
            SYNC_FAIL <= 1'b0;
            BIT_CNT   <= '0;
            ERR_CNT   <= '0;
            len_q     <= TEST_LENGTH;
            good_cnt  <= '0;
            to_cnt    <= '0;
          end
        end
        S_SYNC: begin
          if (STOP) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else if (CLK_EN) begin
            good_cnt <= err_c ? '0 : good_inc_c;
            to_cnt   <= to_inc_c;
            if (!err_c && (good_inc_c == GOOD_W'(SYNC_BITS))) begin
              state  <= S_CHECK;
              LOCKED <= 1'b1;
            end else if (to_inc_c == TO_W'(SYNC_TIMEOUT)) begin
              state     <= S_DONE;
              BUSY      <= 1'b0;
              DONE      <= 1'b1;
              SYNC_FAIL <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (STOP) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else if (CLK_EN) begin
            if (!(&BIT_CNT)) begin
              BIT_CNT <= bit_inc_c[BIT_CNT_W-1:0];
            end
            if (err_c && !(&ERR_CNT)) begin
              ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
            end
            // final sample of a bounded run is counted before leaving
            if ((len_q != '0) && (bit_inc_c == {1'b0, len_q})) begin
              state <= S_DONE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
